// File: rtl/datamover_cmd_scheduler_pkg.sv
// Shared constants for the DataMover command scheduler: tag field placement,
// FSM encodings and error flag bit positions.
package datamover_cmd_scheduler_pkg;

    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_WIDTH = 4;
    localparam int STS_TAG_LSB   = 0;
    localparam int STS_TAG_WIDTH = 4;

    localparam logic [0:0] ST_ARB = 1'b0;
    localparam logic [0:0] ST_CMD = 1'b1;

    localparam int ERR_TAG_MISMATCH = 0;
    localparam int ERR_STS_EMPTY    = 1;
    localparam int ERR_WIDTH        = 2;

    typedef logic [0:0] sched_state_t;

endpackage

// File: rtl/datamover_cmd_scheduler_sid_order_fifo.sv
// Synchronous FIFO of stream indices in command issue order; the count output
// doubles as the outstanding-command counter.
module sid_order_fifo #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty   = (count == '0);
    assign full    = count[ADDR_WIDTH];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/datamover_cmd_scheduler.sv
// Round-robin scheduler sharing one DataMover command/status pair between
// several streams; status beats are routed back in issue order.
module datamover_cmd_scheduler
    import datamover_cmd_scheduler_pkg::*;
#(
    parameter int C_STREAMS_WIDTH         = 2,
    parameter int C_M_AXIS_CMD_DATA_WIDTH = 73,
    parameter int C_M_AXIS_STS_DATA_WIDTH = 8,
    parameter int C_MAX_OUTSTANDING_WIDTH = 3,
    parameter int NUM_STREAMS             = 1 << C_STREAMS_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_STREAMS-1:0]                         stream_enable,
    input  logic [NUM_STREAMS-1:0]                         req_cmd_tvalid,
    output logic [NUM_STREAMS-1:0]                         req_cmd_tready,
    input  logic [NUM_STREAMS*C_M_AXIS_CMD_DATA_WIDTH-1:0] req_cmd_tdata,
    output logic                                           M_AXIS_CMD_TVALID,
    input  logic                                           M_AXIS_CMD_TREADY,
    output logic [C_M_AXIS_CMD_DATA_WIDTH-1:0]             M_AXIS_CMD_TDATA,
    input  logic                                           S_AXIS_STS_TVALID,
    output logic                                           S_AXIS_STS_TREADY,
    input  logic [C_M_AXIS_STS_DATA_WIDTH-1:0]             S_AXIS_STS_TDATA,
    output logic [NUM_STREAMS-1:0]                         rsp_sts_tvalid,
    input  logic [NUM_STREAMS-1:0]                         rsp_sts_tready,
    output logic [C_M_AXIS_STS_DATA_WIDTH-1:0]             rsp_sts_tdata,
    output logic [C_MAX_OUTSTANDING_WIDTH:0]               outstanding,
    output logic [ERR_WIDTH-1:0]                           err_flags,
    input  logic                                           err_clear,
    output logic [31:0]                                    debug
);

    localparam int CW = C_M_AXIS_CMD_DATA_WIDTH;

    // All streams use AXI-Stream semantics: a beat transfers on a rising clk
    // edge where valid and ready are both high; once valid is raised it and
    // the data are held until that transfer, and ready may depend on valid.

    sched_state_t               state;
    logic [C_STREAMS_WIDTH-1:0] grant;
    logic [C_STREAMS_WIDTH-1:0] last_grant;
    logic [C_STREAMS_WIDTH-1:0] pick;
    logic [C_STREAMS_WIDTH-1:0] pick_idx;
    logic                       pick_found;
    logic [NUM_STREAMS-1:0]     eligible;
    logic [CW-1:0]              cmd_slice [NUM_STREAMS];
    logic [CW-1:0]              cmd_out;
    logic                       cmd_fire;

    logic [C_STREAMS_WIDTH-1:0] fifo_head;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       sts_pop;
    logic [STS_TAG_WIDTH-1:0]   sts_tag;
    logic [ERR_WIDTH-1:0]       err_set;

    for (genvar m = 0; m < NUM_STREAMS; m++) begin : g_unpack
        assign cmd_slice[m] = req_cmd_tdata[m*CW +: CW];
    end

    assign eligible = req_cmd_tvalid & stream_enable;
    assign cmd_fire = (state == ST_CMD) & M_AXIS_CMD_TREADY;

    // Search starts just above the last winner so every stream gets a turn.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= NUM_STREAMS; i++) begin
            pick_idx = last_grant + C_STREAMS_WIDTH'(i);
            if (!pick_found && eligible[pick_idx]) begin
                pick       = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            grant      <= '0;
            last_grant <= C_STREAMS_WIDTH'(NUM_STREAMS - 1);
        end else begin
            case (state)
                ST_ARB: begin
                    if (pick_found && !fifo_full) begin
                        grant <= pick;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (M_AXIS_CMD_TREADY) begin
                        last_grant <= grant;
                        state      <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    always_comb begin
        cmd_out = cmd_slice[grant];
        cmd_out[CMD_TAG_LSB +: CMD_TAG_WIDTH] = CMD_TAG_WIDTH'(grant);
    end

    assign M_AXIS_CMD_TVALID = (state == ST_CMD);
    assign M_AXIS_CMD_TDATA  = (state == ST_CMD) ? cmd_out : '0;
    assign req_cmd_tready    = cmd_fire ? (NUM_STREAMS'(1) << grant) : '0;

    sid_order_fifo #(
        .DATA_WIDTH(C_STREAMS_WIDTH),
        .ADDR_WIDTH(C_MAX_OUTSTANDING_WIDTH)
    ) u_order_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_fire),
        .push_data(grant),
        .pop      (sts_pop),
        .head     (fifo_head),
        .count    (outstanding),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // With nothing outstanding the channel is kept drained so a stray beat
    // cannot stall the DataMover.
    assign S_AXIS_STS_TREADY = fifo_empty ? 1'b1 : rsp_sts_tready[fifo_head];
    assign rsp_sts_tvalid    = (!fifo_empty && S_AXIS_STS_TVALID) ?
                               (NUM_STREAMS'(1) << fifo_head) : '0;
    assign rsp_sts_tdata     = S_AXIS_STS_TDATA;
    assign sts_pop           = !fifo_empty && S_AXIS_STS_TVALID && S_AXIS_STS_TREADY;
    assign sts_tag           = S_AXIS_STS_TDATA[STS_TAG_LSB +: STS_TAG_WIDTH];

    always_comb begin
        err_set                   = '0;
        err_set[ERR_TAG_MISMATCH] = sts_pop && (sts_tag != STS_TAG_WIDTH'(fifo_head));
        err_set[ERR_STS_EMPTY]    = fifo_empty && S_AXIS_STS_TVALID;
    end

    // A set in the same cycle as a clear survives so no event is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flags <= '0;
        end else begin
            err_flags <= (err_clear ? '0 : err_flags) | err_set;
        end
    end

    assign debug = 32'({4'(grant), state, 4'(last_grant), outstanding, err_flags});

endmodule
